rm_rule_monitor: RTL and testbench
==================================

# rm_rule_monitor

Parametrised runtime-monitor array: per lane and per rule, a programmable "trigger event must be followed by response event within N cycles" checker over a multi-issue event stream. Violations are sticky per lane/rule and are also serialised into a single report stream through a round-robin arbiter with a valid/ready handshake. Sits after the per-lane event routers, in place of the fixed two-slot monitor, and feeds the RM trap/logging unit.

## Interface
- NUM_LANES, 5, monitored lanes
- NUM_ISSUE, 2, instruction slots per lane per cycle
- NUM_EVENTS, 10, event bits per slot
- NUM_ITYPES, 2, monitored instruction types; ITYPE_W = max(1, $clog2(NUM_ITYPES))
- NUM_RULES, 5, rules, shared by all lanes
- WINDOW_W, 8, width of the response-window counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- ev_valid_i  in  [NUM_LANES][NUM_ISSUE]  slot valid
- ev_itype_i  in  [NUM_LANES][NUM_ISSUE][ITYPE_W]  slot instruction type
- ev_vec_i  in  [NUM_LANES][NUM_ISSUE][NUM_EVENTS]  slot event vector
- halt_i  in  [NUM_LANES]  freeze lane; inputs ignored
- lane_reset_i  in  [NUM_LANES]  synchronous per-lane clear
- cfg_we_i  in  1  rule-table write strobe
- cfg_rule_i  in  $clog2(NUM_RULES)  rule index
- cfg_en_i, cfg_itype_i, cfg_trig_i, cfg_resp_i, cfg_window_i  in  1 / ITYPE_W / $clog2(NUM_EVENTS) / $clog2(NUM_EVENTS) / WINDOW_W  rule fields
- monitor_o  out  [NUM_LANES][NUM_RULES]  sticky violation flags
- rpt_valid_o  out  1  report available
- rpt_ready_i  in  1  consumer accepts report
- rpt_lane_o  out  $clog2(NUM_LANES)  violating lane
- rpt_rule_o  out  $clog2(NUM_RULES)  violated rule

## Operation
- Per cycle, lane l, rule r: trig = any slot s with ev_valid, ev_itype==itype[r], and ev_vec[trig[r]]. resp = any valid slot (any itype) with ev_vec[resp[r]]. Slot order is ignored.
- Per lane/rule FSM, states IDLE and ARMED, with counter cnt.
  - IDLE: trig & !resp -> ARMED, cnt=window[r]. trig & resp -> stay IDLE.
  - ARMED: resp -> IDLE (a simultaneous trig does not re-arm). Otherwise, cnt==0 -> violation; go to ARMED with a fresh window if trig, else IDLE. Otherwise cnt-1. A trig while ARMED does not restart the window.
- Violation sets monitor_o[l][r] and pending[l][r]. If pending is already set, no duplicate is queued.
- Rule disabled (en=0): FSM forced to IDLE, no violations.
- halt_i[l]: that lane's FSMs and counters hold; events are ignored.
- lane_reset_i[l]: clears that lane's FSMs, monitor_o row and pending row. Priority: lane_reset > halt.
- Rule table: cfg_we_i writes all fields of rule cfg_rule_i. An index >= NUM_RULES is ignored. An in-flight cnt keeps its value; new fields apply from the next cycle.
- Report: 1-entry output register. When empty, or popped this cycle (valid & ready), it loads the next pending bit chosen round-robin over flat index l*NUM_RULES+r, starting after the last grant. The loaded pending bit clears on the same edge. A violation on the same edge as the clear re-sets pending (set wins).
- While rpt_valid_o=1 and rpt_ready_i=0, rpt_lane_o and rpt_rule_o hold stable. lane_reset_i does not cancel a report already loaded.
- Reset: monitor_o=0, rpt_valid_o=0, rpt_lane_o=0, rpt_rule_o=0. All FSMs IDLE, cnt=0, pending=0, rule table all zero (disabled), arbiter pointer=0.

## Timing
- Trigger at cycle t: a response is accepted in unhalted cycles t..t+W+1, where W=window. Without a response, the FSM flags at the edge ending cycle t+W+1, and monitor_o is visible in cycle t+W+2.
- rpt_valid_o rises one cycle after monitor_o at the earliest.
- Throughput: one report per cycle while rpt_ready_i=1.
- Counters do not wrap; cnt saturates at 0.

## Structure
- rm_pkg holds: rule_cfg_t struct (en, itype, trig, resp, window), the rm_fsm_e enum {IDLE, ARMED}, and width helper localparams.
- Sub-module rm_rule_fsm: one lane/rule FSM with its counter. It takes trig, resp, halt, lane_reset and cfg, and outputs a single-cycle violation pulse. The top level generates NUM_LANES*NUM_RULES instances; the arbiter and report register are inline.

## Test plan
- Rule0 {en=1, itype=0, trig=3, resp=5, window=2}. Lane1 trig at t=10, resp at t=13 -> no violation. No resp -> monitor_o[1][0]=1 in cycle 14; then rpt_valid_o=1 with lane=1, rule=0 in cycle 15.
- Same rule with trig and resp in different slots of one cycle -> stays IDLE. Trig with wrong itype -> never arms.
- halt_i[1] for 4 cycles inside the window -> the flag appears 4 cycles later. lane_reset_i[1] while ARMED -> no flag, and monitor_o row 1 is cleared.
- Violations on lanes 0, 2 and 4 for rule 1 on the same edge, with rpt_ready_i=0 for 3 cycles -> the report stays at lane 0. Then, with ready=1, reports come out lane 0, 2, 4 on consecutive cycles.
- rst_i asserted mid-ARMED and with a report pending -> all outputs 0 immediately (async). After release, no report and the table is disabled.
- window=0: trig at t, resp at t+1 -> pass. No resp -> flagged in cycle t+2. Cfg write to rule index 7 with NUM_RULES=5 -> table unchanged.

Source files
------------

// File: rtl/rm_pkg.sv
// Shared types and default geometry for the rule-monitor array.
package rm_pkg;

    // Width of an index into n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RM_NUM_LANES  = 5;
    localparam int RM_NUM_ISSUE  = 2;
    localparam int RM_NUM_EVENTS = 10;
    localparam int RM_NUM_ITYPES = 2;
    localparam int RM_NUM_RULES  = 5;
    localparam int RM_WINDOW_W   = 8;

    localparam int RM_ITYPE_W = clog2_min1(RM_NUM_ITYPES);
    localparam int RM_EVIDX_W = clog2_min1(RM_NUM_EVENTS);

    localparam logic [RM_WINDOW_W-1:0] RM_CNT_ONE = {{(RM_WINDOW_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } rm_fsm_e;

    typedef struct packed {
        logic                   en;
        logic [RM_ITYPE_W-1:0]  itype;
        logic [RM_EVIDX_W-1:0]  trig;
        logic [RM_EVIDX_W-1:0]  resp;
        logic [RM_WINDOW_W-1:0] window;
    } rule_cfg_t;

endpackage

// File: rtl/rm_rule_fsm.sv
// One lane/rule checker: after a trigger, a response must arrive within the
// programmed window, otherwise a one-cycle violation pulse is produced.
module rm_rule_fsm
    import rm_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      trig_i,
    input  logic      resp_i,
    input  logic      halt_i,
    input  logic      lane_reset_i,
    input  rule_cfg_t cfg_i,
    output logic      viol_o
);

    rm_fsm_e                state_q, state_d;
    logic [RM_WINDOW_W-1:0] cnt_q, cnt_d;
    logic                   viol_s;

    // Next state, window countdown and violation pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        viol_s  = 1'b0;
        if (lane_reset_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (halt_i) begin
            // Frozen lane: state and counter hold, events are ignored.
            state_d = state_q;
            cnt_d   = cnt_q;
        end else if (!cfg_i.en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trig_i && !resp_i) begin
                        state_d = ARMED;
                        cnt_d   = cfg_i.window;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ARMED: begin
                    if (resp_i) begin
                        // A coincident trigger is satisfied by this response too.
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        viol_s = 1'b1;
                        if (trig_i) begin
                            state_d = ARMED;
                            cnt_d   = cfg_i.window;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        // Retriggers do not restart a running window.
                        cnt_d = cnt_q - RM_CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign viol_o = viol_s;

endmodule

// File: rtl/rm_rule_monitor.sv
// Runtime monitor array: one trigger/response checker per lane and rule,
// sticky violation flags, and a round-robin serialised report stream.
module rm_rule_monitor
    import rm_pkg::*;
#(
    parameter int  NUM_LANES  = RM_NUM_LANES,
    parameter int  NUM_ISSUE  = RM_NUM_ISSUE,
    parameter int  NUM_EVENTS = RM_NUM_EVENTS,
    parameter int  NUM_ITYPES = RM_NUM_ITYPES,
    parameter int  NUM_RULES  = RM_NUM_RULES,
    parameter int  WINDOW_W   = RM_WINDOW_W,
    localparam int ITYPE_W    = clog2_min1(NUM_ITYPES),
    localparam int EVIDX_W    = clog2_min1(NUM_EVENTS),
    localparam int LANE_W     = clog2_min1(NUM_LANES),
    localparam int RULE_W     = clog2_min1(NUM_RULES)
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic [NUM_LANES-1:0][NUM_ISSUE-1:0]              ev_valid_i,
    input  logic [NUM_LANES-1:0][NUM_ISSUE-1:0][ITYPE_W-1:0] ev_itype_i,
    input  logic [NUM_LANES-1:0][NUM_ISSUE-1:0][NUM_EVENTS-1:0] ev_vec_i,
    input  logic [NUM_LANES-1:0]                             halt_i,
    input  logic [NUM_LANES-1:0]                             lane_reset_i,
    input  logic                                             cfg_we_i,
    input  logic [RULE_W-1:0]                                cfg_rule_i,
    input  logic                                             cfg_en_i,
    input  logic [ITYPE_W-1:0]                               cfg_itype_i,
    input  logic [EVIDX_W-1:0]                               cfg_trig_i,
    input  logic [EVIDX_W-1:0]                               cfg_resp_i,
    input  logic [WINDOW_W-1:0]                              cfg_window_i,
    output logic [NUM_LANES-1:0][NUM_RULES-1:0]              monitor_o,
    output logic                                             rpt_valid_o,
    input  logic                                             rpt_ready_i,
    output logic [LANE_W-1:0]                                rpt_lane_o,
    output logic [RULE_W-1:0]                                rpt_rule_o
);

    localparam int NF    = NUM_LANES * NUM_RULES;
    localparam int PTR_W = clog2_min1(NF);
    localparam int SUM_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NF - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    rule_cfg_t                          cfg_q [NUM_RULES];
    rule_cfg_t                          cfg_d [NUM_RULES];
    logic [NUM_LANES-1:0][NUM_RULES-1:0] monitor_q, monitor_d;
    logic [NUM_LANES-1:0][NUM_RULES-1:0] pending_q, pending_d;
    logic                               rpt_valid_q, rpt_valid_d;
    logic [LANE_W-1:0]                  rpt_lane_q, rpt_lane_d;
    logic [RULE_W-1:0]                  rpt_rule_q, rpt_rule_d;
    logic [PTR_W-1:0]                   ptr_q, ptr_d;

    logic [NUM_LANES-1:0][NUM_RULES-1:0] trig_s, resp_s, viol_s;
    logic [NF-1:0]                      pend_flat_s;
    logic                               found_s, load_s;
    logic [PTR_W-1:0]                   gidx_s;
    logic [SUM_W-1:0]                   sum_s;
    logic [LANE_W-1:0]                  glane_s;
    logic [RULE_W-1:0]                  grule_s;

    // Rule-table write; out-of-range indices are dropped.
    always_comb begin
        cfg_d = cfg_q;
        if (cfg_we_i && (int'(cfg_rule_i) < NUM_RULES)) begin
            cfg_d[cfg_rule_i].en     = cfg_en_i;
            cfg_d[cfg_rule_i].itype  = cfg_itype_i;
            cfg_d[cfg_rule_i].trig   = cfg_trig_i;
            cfg_d[cfg_rule_i].resp   = cfg_resp_i;
            cfg_d[cfg_rule_i].window = cfg_window_i;
        end else begin
            cfg_d = cfg_q;
        end
    end

    // Per lane/rule trigger and response detection across all issue slots.
    always_comb begin
        trig_s = '0;
        resp_s = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int r = 0; r < NUM_RULES; r++) begin
                for (int s = 0; s < NUM_ISSUE; s++) begin
                    trig_s[l][r] = trig_s[l][r]
                                 | (ev_valid_i[l][s]
                                    & (ev_itype_i[l][s] == cfg_q[r].itype)
                                    & (int'(cfg_q[r].trig) < NUM_EVENTS)
                                    & ev_vec_i[l][s][cfg_q[r].trig]);
                    resp_s[l][r] = resp_s[l][r]
                                 | (ev_valid_i[l][s]
                                    & (int'(cfg_q[r].resp) < NUM_EVENTS)
                                    & ev_vec_i[l][s][cfg_q[r].resp]);
                end
            end
        end
    end

    for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
        for (genvar gr = 0; gr < NUM_RULES; gr++) begin : g_rule
            rm_rule_fsm u_fsm (
                .clk_i        (clk_i),
                .rst_i        (rst_i),
                .trig_i       (trig_s[gl][gr]),
                .resp_i       (resp_s[gl][gr]),
                .halt_i       (halt_i[gl]),
                .lane_reset_i (lane_reset_i[gl]),
                .cfg_i        (cfg_q[gr]),
                .viol_o       (viol_s[gl][gr])
            );
        end
    end

    assign pend_flat_s = pending_q;

    // Round-robin search over the flattened pending vector, starting at ptr_q.
    always_comb begin
        found_s = 1'b0;
        gidx_s  = '0;
        sum_s   = '0;
        for (int i = 0; i < NF; i++) begin
            sum_s = {1'b0, ptr_q} + SUM_W'(i);
            if (sum_s >= SUM_W'(NF)) begin
                sum_s = sum_s - SUM_W'(NF);
            end else begin
                sum_s = sum_s;
            end
            if (!found_s && pend_flat_s[sum_s[PTR_W-1:0]]) begin
                found_s = 1'b1;
                gidx_s  = sum_s[PTR_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
        glane_s = LANE_W'(int'(gidx_s) / NUM_RULES);
        grule_s = RULE_W'(int'(gidx_s) % NUM_RULES);
    end

    // Report register, pending/monitor bookkeeping and arbiter pointer.
    always_comb begin
        load_s      = !rpt_valid_q || rpt_ready_i;
        rpt_valid_d = rpt_valid_q;
        rpt_lane_d  = rpt_lane_q;
        rpt_rule_d  = rpt_rule_q;
        ptr_d       = ptr_q;
        pending_d   = pending_q;
        if (load_s) begin
            rpt_valid_d = found_s;
            if (found_s) begin
                rpt_lane_d                  = glane_s;
                rpt_rule_d                  = grule_s;
                ptr_d                       = (gidx_s == PTR_LAST) ? '0 : gidx_s + PTR_ONE;
                pending_d[glane_s][grule_s] = 1'b0;
            end else begin
                ptr_d = ptr_q;
            end
        end else begin
            rpt_valid_d = rpt_valid_q;
        end
        // A new violation wins over the grant clear on the same edge.
        pending_d = pending_d | viol_s;
        monitor_d = monitor_q | viol_s;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_reset_i[l]) begin
                pending_d[l] = '0;
                monitor_d[l] = '0;
            end else begin
                pending_d[l] = pending_d[l];
            end
        end
    end

    // State registers of the top level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_RULES; r++) begin
                cfg_q[r] <= '0;
            end
            monitor_q   <= '0;
            pending_q   <= '0;
            rpt_valid_q <= 1'b0;
            rpt_lane_q  <= '0;
            rpt_rule_q  <= '0;
            ptr_q       <= '0;
        end else begin
            cfg_q       <= cfg_d;
            monitor_q   <= monitor_d;
            pending_q   <= pending_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_lane_q  <= rpt_lane_d;
            rpt_rule_q  <= rpt_rule_d;
            ptr_q       <= ptr_d;
        end
    end

    assign monitor_o   = monitor_q;
    assign rpt_valid_o = rpt_valid_q;
    assign rpt_lane_o  = rpt_lane_q;
    assign rpt_rule_o  = rpt_rule_q;

endmodule

// File: tb/tb_rm_rule_monitor.sv
// Directed, table-driven bench for rm_rule_monitor.
module tb_rm_rule_monitor;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [4:0][1:0]       ev_valid;
    logic [4:0][1:0][0:0]  ev_itype;
    logic [4:0][1:0][9:0]  ev_vec;
    logic [4:0]            halt;
    logic [4:0]            lane_reset;
    logic                  cfg_we;
    logic [2:0]            cfg_rule;
    logic                  cfg_en;
    logic [0:0]            cfg_itype;
    logic [3:0]            cfg_trig;
    logic [3:0]            cfg_resp;
    logic [7:0]            cfg_window;
    logic [4:0][4:0]       monitor;
    logic                  rpt_valid;
    logic                  rpt_ready;
    logic [2:0]            rpt_lane;
    logic [2:0]            rpt_rule;

    rm_rule_monitor dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ev_valid_i   (ev_valid),
        .ev_itype_i   (ev_itype),
        .ev_vec_i     (ev_vec),
        .halt_i       (halt),
        .lane_reset_i (lane_reset),
        .cfg_we_i     (cfg_we),
        .cfg_rule_i   (cfg_rule),
        .cfg_en_i     (cfg_en),
        .cfg_itype_i  (cfg_itype),
        .cfg_trig_i   (cfg_trig),
        .cfg_resp_i   (cfg_resp),
        .cfg_window_i (cfg_window),
        .monitor_o    (monitor),
        .rpt_valid_o  (rpt_valid),
        .rpt_ready_i  (rpt_ready),
        .rpt_lane_o   (rpt_lane),
        .rpt_rule_o   (rpt_rule)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  trig;   // lanes with trigger event in slot 0
        logic [4:0]  resp;   // lanes with response event in slot 1
        logic [4:0]  halt;
        logic [4:0]  lrst;
        logic        ready;
        logic [3:0]  tb;
        logic [3:0]  rb;
        logic        it;
        logic [24:0] mon;    // expected monitor_o after the edge
        logic        v;
        logic [2:0]  lane;
        logic [2:0]  rule;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;
    int   vnum   = 0;
    logic [3:0] cur_tb = 4'd3;
    logic [3:0] cur_rb = 4'd5;
    logic       cur_it = 1'b0;

    localparam logic [4:0]  L1  = 5'b00010;
    localparam logic [4:0]  LA  = 5'b10101;
    localparam logic [24:0] M10 = 25'h0000020;   // lane 1, rule 0
    localparam logic [24:0] MA  = 25'h0200802;   // lanes 0,2,4, rule 1

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [4:0] tr, input logic [4:0] rs, input logic [4:0] hl,
                        input logic [4:0] lr, input logic rd, input logic [24:0] m,
                        input logic ev, input logic [2:0] el, input logic [2:0] er);
        vec_t x;
        x.trig = tr; x.resp = rs; x.halt = hl; x.lrst = lr; x.ready = rd;
        x.tb = cur_tb; x.rb = cur_rb; x.it = cur_it;
        x.mon = m; x.v = ev; x.lane = el; x.rule = er;
        vq.push_back(x);
    endtask

    task automatic idle_inputs();
        ev_valid = '0; ev_itype = '0; ev_vec = '0;
        halt = '0; lane_reset = '0; cfg_we = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [24:0] m, input logic ev,
                                 input logic [2:0] el, input logic [2:0] er);
        logic [24:0] mon_flat;
        mon_flat = monitor;
        check({tag, ".mon"}, 32'(mon_flat), 32'(m));
        check({tag, ".valid"}, 32'(rpt_valid), 32'(ev));
        if (ev) begin
            check({tag, ".lane"}, 32'(rpt_lane), 32'(el));
            check({tag, ".rule"}, 32'(rpt_rule), 32'(er));
        end
    endtask

    task automatic run_vecs();
        foreach (vq[i]) begin
            idle_inputs();
            for (int l = 0; l < 5; l++) begin
                if (vq[i].trig[l]) begin
                    ev_valid[l][0] = 1'b1;
                    ev_itype[l][0] = vq[i].it;
                    ev_vec[l][0][vq[i].tb] = 1'b1;
                end
                if (vq[i].resp[l]) begin
                    ev_valid[l][1] = 1'b1;
                    ev_itype[l][1] = 1'b1;
                    ev_vec[l][1][vq[i].rb] = 1'b1;
                end
            end
            halt       = vq[i].halt;
            lane_reset = vq[i].lrst;
            rpt_ready  = vq[i].ready;
            @(posedge clk);
            #1;
            check_outputs($sformatf("v%0d", vnum), vq[i].mon, vq[i].v, vq[i].lane, vq[i].rule);
            vnum++;
        end
        vq.delete();
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic en, input logic it,
                             input logic [3:0] tb, input logic [3:0] rb, input logic [7:0] w);
        idle_inputs();
        cfg_we = 1'b1; cfg_rule = idx; cfg_en = en; cfg_itype = it;
        cfg_trig = tb; cfg_resp = rb; cfg_window = w;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1; rpt_ready = 1'b1;
        cfg_rule = 3'd0; cfg_en = 1'b0; cfg_itype = 1'b0;
        cfg_trig = 4'd0; cfg_resp = 4'd0; cfg_window = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 25'h0, 1'b0, 3'd0, 3'd0);
        check("reset.lane", 32'(rpt_lane), 32'd0);
        check("reset.rule", 32'(rpt_rule), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Rule 0: itype 0, trig 3, resp 5, window 2.
        cfg_write(3'd0, 1'b1, 1'b0, 4'd3, 4'd5, 8'd2);
        // Response in the last accepted cycle t+3.
        push(L1, 0, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 1, 0, 0, 0, 0);
        push(0, L1, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 1, 0, 0, 0, 0);
        // No response: flag in t+4, report in t+5.
        push(L1, 0, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 1, M10, 0, 0, 0);
        push(0, 0, 0, 0, 1, M10, 1, 3'd1, 3'd0);
        push(0, 0, 0, 0, 1, M10, 0, 0, 0);
        push(0, 0, 0, L1, 1, 0, 0, 0, 0);
        // Trigger and response in one cycle, different slots.
        push(L1, L1, 0, 0, 1, 0, 0, 0, 0);
        repeat (4) push(0, 0, 0, 0, 1, 0, 0, 0, 0);
        // Trigger with wrong itype.
        cur_it = 1'b1;
        push(L1, 0, 0, 0, 1, 0, 0, 0, 0);
        cur_it = 1'b0;
        repeat (4) push(0, 0, 0, 0, 1, 0, 0, 0, 0);
        // Halt for 4 cycles inside the window delays the flag by 4.
        push(L1, 0, 0, 0, 1, 0, 0, 0, 0);
        repeat (4) push(0, 0, L1, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 1, M10, 0, 0, 0);
        push(0, 0, 0, 0, 1, M10, 1, 3'd1, 3'd0);
        push(0, 0, 0, 0, 1, M10, 0, 0, 0);
        // Lane reset while armed clears the row and cancels the check.
        push(L1, 0, 0, 0, 1, M10, 0, 0, 0);
        push(0, 0, 0, L1, 1, 0, 0, 0, 0);
        repeat (4) push(0, 0, 0, 0, 1, 0, 0, 0, 0);
        run_vecs();

        // Window 0.
        cfg_write(3'd0, 1'b1, 1'b0, 4'd3, 4'd5, 8'd0);
        push(L1, 0, 0, 0, 1, 0, 0, 0, 0);
        push(0, L1, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 1, 0, 0, 0, 0);
        push(L1, 0, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 1, M10, 0, 0, 0);
        push(0, 0, 0, 0, 1, M10, 1, 3'd1, 3'd0);
        push(0, 0, 0, 0, 1, M10, 0, 0, 0);
        run_vecs();

        // Write to out-of-range rule 7 leaves the table unchanged.
        cfg_write(3'd7, 1'b0, 1'b1, 4'd1, 4'd1, 8'd9);
        push(0, 0, 0, L1, 1, 0, 0, 0, 0);
        push(L1, 0, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 1, M10, 0, 0, 0);
        push(0, 0, 0, 0, 1, M10, 1, 3'd1, 3'd0);
        push(0, 0, 0, 0, 1, M10, 0, 0, 0);
        run_vecs();

        // Disabled rule never flags.
        cfg_write(3'd0, 1'b0, 1'b0, 4'd3, 4'd5, 8'd0);
        push(0, 0, 0, L1, 1, 0, 0, 0, 0);
        push(L1, 0, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 1, 0, 0, 0, 0);
        run_vecs();

        // Build a held report and an armed FSM, then reset asynchronously.
        cfg_write(3'd0, 1'b1, 1'b0, 4'd3, 4'd5, 8'd0);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(L1, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, M10, 0, 0, 0);
        push(L1, 0, 0, 0, 0, M10, 1, 3'd1, 3'd0);
        run_vecs();
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 25'h0, 1'b0, 3'd0, 3'd0);
        check("async_rst.lane", 32'(rpt_lane), 32'd0);
        check("async_rst.rule", 32'(rpt_rule), 32'd0);
        idle_inputs();
        rpt_ready = 1'b1;
        @(negedge clk) rst = 1'b0;
        // Table is disabled after reset and no report is left.
        push(0, 0, 0, 0, 1, 0, 0, 0, 0);
        push(L1, 0, 0, 0, 1, 0, 0, 0, 0);
        repeat (3) push(0, 0, 0, 0, 1, 0, 0, 0, 0);
        run_vecs();

        // Rule 1 on lanes 0, 2, 4 simultaneously; consumer stalls first.
        cfg_write(3'd1, 1'b1, 1'b0, 4'd7, 4'd8, 8'd0);
        cur_tb = 4'd7;
        cur_rb = 4'd8;
        push(LA, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, MA, 0, 0, 0);
        repeat (4) push(0, 0, 0, 0, 0, MA, 1, 3'd0, 3'd1);
        push(0, 0, 0, 0, 1, MA, 1, 3'd2, 3'd1);
        push(0, 0, 0, 0, 1, MA, 1, 3'd4, 3'd1);
        push(0, 0, 0, 0, 1, MA, 0, 0, 0);
        run_vecs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
